// File: rtl/ntt_pe_core.sv
// Radix-2 DIT NTT engine: bit-reversed load buffer, butterfly sequencer and modular PE in one block.
// Build option: define MOD_CHECK_EN to reduce every loaded coefficient mod q before storing it.
module ntt_pe_core #(
  parameter int DATA_SIZE_ARB = 13,
  parameter int RING_SIZE     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid,
  input  logic [DATA_SIZE_ARB-1:0]     din,
  input  logic [DATA_SIZE_ARB-1:0]     q,
  input  logic [DATA_SIZE_ARB-1:0]     twiddle_i,
  output logic [$clog2(RING_SIZE)-1:0] tw_addr,
  output logic [11:0]                  stage,
  output logic                         busy,
  output logic [DATA_SIZE_ARB-1:0]     dout,
  output logic                         dout_valid,
  output logic                         done
);

  localparam int LOG = $clog2(RING_SIZE);
  localparam int W   = DATA_SIZE_ARB;
  localparam int W2  = 2 * DATA_SIZE_ARB;
  localparam logic [LOG-1:0] LAST_IDX = LOG'(RING_SIZE - 1);
  localparam logic [LOG-1:0] LAST_K   = LOG'(RING_SIZE / 2 - 1);
  localparam logic [LOG-1:0] LAST_S   = LOG'(LOG - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

  state_t         state, state_nx;
  logic [LOG-1:0] cnt;
  logic [LOG-1:0] s;
  logic [W-1:0]   mem [RING_SIZE];

  logic [LOG-1:0] half, j, top, bot;
  logic [W2-1:0]  prod;
  logic [W-1:0]   t, a, din_w;
  logic [W:0]     sum, diff, sum_m, diff_m;
  logic           last_bfly;

  function automatic logic [LOG-1:0] bitrev(input logic [LOG-1:0] x);
    for (int b = 0; b < LOG; b++) bitrev[b] = x[LOG-1-b];
  endfunction

`ifdef MOD_CHECK_EN
  assign din_w = din % q;
`else
  assign din_w = din;
`endif

  // Butterfly addressing for butterfly k=cnt of stage s.
  always_comb begin
    half      = LOG'(1) << s;
    j         = cnt & (half - 1'b1);
    top       = ((cnt >> s) << (s + 1'b1)) + j;
    bot       = top + half;
    last_bfly = (cnt == LAST_K) && (s == LAST_S);
  end

  // Modular PE: both results derive from the pre-update mem[top]; sums keep the carry bit.
  always_comb begin
    a      = mem[top];
    prod   = W2'(twiddle_i) * W2'(mem[bot]);
    t      = W'(prod % W2'(q));
    sum    = {1'b0, a} + {1'b0, t};
    diff   = {1'b0, a} + {1'b0, q} - {1'b0, t};
    sum_m  = (sum  >= {1'b0, q}) ? sum  - {1'b0, q} : sum;
    diff_m = (diff >= {1'b0, q}) ? diff - {1'b0, q} : diff;
  end

  // valid qualifies din for one cycle; there is no backpressure and valid is ignored once busy.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid) state_nx = LOAD;
      LOAD:    if (valid && cnt == LAST_IDX) state_nx = COMPUTE;
      COMPUTE: if (last_bfly) state_nx = OUTPUT;
      OUTPUT:  if (cnt == LAST_IDX) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      s          <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (valid) begin
            mem[bitrev(cnt)] <= din_w;
            cnt              <= cnt + 1'b1;
          end
        end
        COMPUTE: begin
          mem[top] <= sum_m[W-1:0];
          mem[bot] <= diff_m[W-1:0];
          if (cnt == LAST_K) begin
            cnt <= '0;
            s   <= last_bfly ? '0 : s + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUTPUT: begin
          dout       <= mem[cnt];
          dout_valid <= 1'b1;
          done       <= (cnt == LAST_IDX);
          cnt        <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // busy spans the registered last output beat so it drops together with dout_valid.
  assign busy    = (state == COMPUTE) || (state == OUTPUT) || dout_valid;
  assign stage   = (state == COMPUTE) ? 12'(s) : 12'd0;
  assign tw_addr = (state == COMPUTE) ? (j << (LAST_S - s)) : '0;

endmodule

// File: tb/tb_ntt_pe_core.sv
// Directed bench for ntt_pe_core: N=4/q=17 transforms (timing, twiddle order, stall, reset abort)
// and an N=16 all-zero transform; MOD_CHECK_EN builds also load out-of-range coefficients.
module tb_ntt_pe_core;

  localparam int W = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  // N=4 instance
  logic         r4, v4, busy4, dv4, dn4;
  logic [W-1:0] d4, q4, tw4, do4;
  logic [1:0]   ta4;
  logic [11:0]  st4;

  // N=16 instance
  logic         r16, v16, busy16, dv16, dn16;
  logic [W-1:0] d16, q16, tw16, do16;
  logic [3:0]   ta16;
  logic [11:0]  st16;

  ntt_pe_core #(.DATA_SIZE_ARB(W), .RING_SIZE(4)) dut4 (
    .clk(clk), .reset(r4), .valid(v4), .din(d4), .q(q4), .twiddle_i(tw4),
    .tw_addr(ta4), .stage(st4), .busy(busy4), .dout(do4), .dout_valid(dv4), .done(dn4)
  );

  ntt_pe_core #(.DATA_SIZE_ARB(W), .RING_SIZE(16)) dut16 (
    .clk(clk), .reset(r16), .valid(v16), .din(d16), .q(q16), .twiddle_i(tw16),
    .tw_addr(ta16), .stage(st16), .busy(busy16), .dout(do16), .dout_valid(dv16), .done(dn16)
  );

  // Twiddle table 4^e mod 17
  always_comb begin
    case (ta4)
      2'd0:    tw4 = 13'd1;
      2'd1:    tw4 = 13'd4;
      2'd2:    tw4 = 13'd16;
      default: tw4 = 13'd13;
    endcase
  end
  assign tw16 = 13'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load4(input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic [W-1:0] a2, input logic [W-1:0] a3,
                       input int stall, output int unsigned t0);
    logic [W-1:0] v[4];
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) repeat (stall) begin @(negedge clk); v4 = 1'b0; end
      @(negedge clk);
      v4 = 1'b1;
      d4 = v[i];
      if (i == 0) t0 = cyc;
    end
    @(negedge clk);
    v4 = 1'b0;
    d4 = '0;
  endtask

  // Called on the first COMPUTE cycle; expects tw_addr 0,0,0,1 and stage 0,0,1,1.
  task automatic check_compute4();
    for (int i = 0; i < 4; i++) begin
      check("tw_addr", 32'(ta4), (i == 3) ? 32'd1 : 32'd0);
      check("stage", 32'(st4), 32'(i / 2));
      check("busy_compute", 32'(busy4), 32'd1);
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic collect4(input string tag, input int unsigned t0, input bit chk_lat);
    int guard = 0;
    while (!dv4 && guard < 200) begin @(negedge clk); guard++; end
    if (!dv4) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      exp_q.delete();
      return;
    end
    // First sample presented at t0; 4 load + 4 butterfly edges + 1 output register edge.
    if (chk_lat) check({tag, " latency"}, cyc - t0, 32'd9);
    for (int i = 0; i < 4; i++) begin
      check({tag, " dout_valid"}, 32'(dv4), 32'd1);
      check({tag, " busy"}, 32'(busy4), 32'd1);
      check({tag, " dout"}, 32'(do4), 32'(exp_q.pop_front()));
      check({tag, " done"}, 32'(dn4), (i == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check({tag, " busy_after"}, 32'(busy4), 32'd0);
    check({tag, " dv_after"}, 32'(dv4), 32'd0);
    check({tag, " done_after"}, 32'(dn4), 32'd0);
  endtask

  task automatic push_ref4();
    exp_q.push_back(13'd10);
    exp_q.push_back(13'd7);
    exp_q.push_back(13'd15);
    exp_q.push_back(13'd6);
  endtask

  initial begin
    int unsigned t0;
    int guard;
    r4 = 1'b0; v4 = 1'b0; d4 = '0; q4 = 13'd17;
    r16 = 1'b0; v16 = 1'b0; d16 = '0; q16 = 13'h12c1;
    repeat (3) @(negedge clk);

    check("rst tw_addr", 32'(ta4), 32'd0);
    check("rst stage", 32'(st4), 32'd0);
    check("rst busy", 32'(busy4), 32'd0);
    check("rst dout", 32'(do4), 32'd0);
    check("rst dout_valid", 32'(dv4), 32'd0);
    check("rst done", 32'(dn4), 32'd0);
    check("rst16 busy", 32'(busy16), 32'd0);
    check("rst16 dout_valid", 32'(dv16), 32'd0);
    r4 = 1'b1; r16 = 1'b1;
    @(negedge clk);

    // Basic transform with cycle-count check
    push_ref4();
    load4(13'd1, 13'd2, 13'd3, 13'd4, 0, t0);
    check_compute4();
    collect4("basic", t0, 1'b1);

    // Three idle cycles between samples 2 and 3
    push_ref4();
    load4(13'd1, 13'd2, 13'd3, 13'd4, 3, t0);
    check_compute4();
    collect4("stall", t0, 1'b0);

    // Abort in the middle of COMPUTE, then a fresh load
    load4(13'd4, 13'd3, 13'd2, 13'd1, 0, t0);
    @(negedge clk);
    check("pre_abort busy", 32'(busy4), 32'd1);
    r4 = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy4), 32'd0);
    check("abort stage", 32'(st4), 32'd0);
    check("abort dout_valid", 32'(dv4), 32'd0);
    check("abort tw_addr", 32'(ta4), 32'd0);
    r4 = 1'b1;
    @(negedge clk);
    push_ref4();
    load4(13'd1, 13'd2, 13'd3, 13'd4, 0, t0);
    check_compute4();
    collect4("after_abort", t0, 1'b1);

`ifdef MOD_CHECK_EN
    push_ref4();
    load4(13'd18, 13'd19, 13'd20, 13'd21, 0, t0);
    check_compute4();
    collect4("modcheck", t0, 1'b1);
`endif

    // N=16 all-zero transform, q=4801
    for (int i = 0; i < 16; i++) exp_q.push_back('0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v16 = 1'b1;
      d16 = '0;
    end
    @(negedge clk);
    v16 = 1'b0;
    check("n16 busy_compute", 32'(busy16), 32'd1);
    guard = 0;
    while (!dv16 && guard < 500) begin @(negedge clk); guard++; end
    if (!dv16) begin
      check("n16 timeout", 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < 16; i++) begin
        check("n16 dout_valid", 32'(dv16), 32'd1);
        check("n16 dout", 32'(do16), 32'(exp_q.pop_front()));
        check("n16 done", 32'(dn16), (i == 15) ? 32'd1 : 32'd0);
        @(negedge clk);
      end
      check("n16 busy_after", 32'(busy16), 32'd0);
      check("n16 dv_after", 32'(dv16), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
